mac_pair_sequencer: RTL

//  Sequences a square matrix-vector product y = M*x through one dual 16x16 multiply-add unit.
//  Per cycle: one column pair of one row is issued (two coef reads, two vector reads).

---
 rtl/mac_seq_pkg.sv | 34 +++
 rtl/mac_pair_sequencer_tag_pipe.sv | 33 +++
 rtl/mac_pair_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_pkg
//  Description : Shared types for the MAC pair sequencer. Defines the tag that
//                travels alongside each issued column pair and the FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    // Tag row field width. It is wide enough for matrices up to 256 rows; the
    // top zero-extends its row counter into this field.
    localparam int TAG_ROW_W = 8;

    // One issued column pair: valid bit, closes-a-row flag, owning row
    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [TAG_ROW_W-1:0] row;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } fsm_t;

    // Address width that never collapses to zero bits (a single pair still
    // needs a one-bit index port)
    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_pair_sequencer_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tag_pipe
//  Description : Fixed-depth shift register of issue tags. Stage i holds the
//                tag issued i+1 cycles ago. A synchronous clear drops every
//                tag in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tag_pipe
    import mac_seq_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  tag_t                 in_tag,
    output tag_t [DEPTH-1:0]     stages
);

    // Advance every tag one stage per cycle; reset empties the pipe
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_pair_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pair_sequencer
//  Description : Streams y = M*x through an external dual 16x16 multiply-add
//                unit, one column pair per cycle. A tag pipeline tracks each
//                pair through RAM and MAC latency so results can be summed
//                per row; one row sum is emitted per row.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_pair_sequencer
    import mac_seq_pkg::*;
#(
    parameter int N       = 8,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 3,
    parameter int ACC_W   = 36
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     hold,
    output logic                                     busy,
    output logic                                     done,
    output logic [$clog2(N*N/2)-1:0]                 coef_addr,
    input  logic [15:0]                              coef_0,
    input  logic [15:0]                              coef_1,
    output logic [((N > 2) ? $clog2(N/2) : 1)-1:0]   vec_addr,
    input  logic [15:0]                              vec_0,
    input  logic [15:0]                              vec_1,
    output logic                                     mac_ena,
    output logic [15:0]                              mac_a0,
    output logic [15:0]                              mac_b0,
    output logic [15:0]                              mac_a1,
    output logic [15:0]                              mac_b1,
    input  logic [32:0]                              mac_result,
    output logic                                     out_valid,
    output logic [$clog2(N)-1:0]                     out_row,
    output logic [ACC_W-1:0]                         out_sum
);

    localparam int PAIRS  = N / 2;
    localparam int PIPE_D = MEM_LAT + 1 + MAC_LAT;
    localparam int ROW_W  = $clog2(N);
    localparam int VEC_AW = clog2_min1(PAIRS);
    localparam int CA_W   = $clog2(N * N / 2);

    localparam logic [ROW_W-1:0]  C_LAST_ROW = ROW_W'(N - 1);
    localparam logic [VEC_AW-1:0] C_LAST_K   = VEC_AW'(PAIRS - 1);
    localparam logic [CA_W-1:0]   C_PAIRS    = CA_W'(PAIRS);

    fsm_t                r_state;
    logic [ROW_W-1:0]    r_row;
    logic [VEC_AW-1:0]   r_k;
    logic [ACC_W-1:0]    r_acc;

    logic                w_issue;
    logic                w_last_k;
    logic                w_upstream_busy;
    logic                w_unused_tag;
    tag_t                w_issue_tag;
    tag_t                w_mem_tag;
    tag_t                w_exit_tag;
    tag_t [PIPE_D-1:0]   w_stages;

    assign w_last_k  = (r_k == C_LAST_K);
    assign w_issue   = (r_state == S_ISSUE) && !hold;

    // Addresses follow the counters directly, so a hold freezes them as well
    assign coef_addr = CA_W'(r_row) * C_PAIRS + CA_W'(r_k);
    assign vec_addr  = r_k;

    // Tag describing the pair whose addresses are on the bus this cycle
    always_comb begin
        w_issue_tag       = '0;
        w_issue_tag.valid = w_issue;
        w_issue_tag.last  = w_last_k;
        w_issue_tag.row   = TAG_ROW_W'(r_row);
    end

    mac_tag_pipe #(
        .DEPTH  (PIPE_D)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .in_tag (w_issue_tag),
        .stages (w_stages)
    );

    // The tag that lines up with RAM read data this cycle
    generate
        if (MEM_LAT == 0) begin : g_mem_tag_issue
            assign w_mem_tag = w_issue_tag;
        end else begin : g_mem_tag_pipe
            assign w_mem_tag = w_stages[MEM_LAT-1];
        end
    endgenerate

    // Last stage lines up with mac_result for the same pair
    assign w_exit_tag   = w_stages[PIPE_D-1];

    // Only valid/last/row of selected stages are consumed; fold the rest
    assign w_unused_tag = ^w_stages;

    // Anything still in flight ahead of the exit stage keeps the drain going
    always_comb begin
        w_upstream_busy = 1'b0;
        for (int i = 0; i < PIPE_D - 1; i++) begin
            w_upstream_busy = w_upstream_busy | w_stages[i].valid;
        end
    end

    // Control FSM: accept start, walk row/k counters, drain, flag completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_ena <= 1'b0;
            r_row   <= '0;
            r_k     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        busy    <= 1'b1;
                        mac_ena <= 1'b1;
                        r_row   <= '0;
                        r_k     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        if (w_last_k) begin
                            r_k   <= '0;
                            r_row <= r_row + ROW_W'(1);
                            if (r_row == C_LAST_ROW) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_k <= r_k + VEC_AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Exit stage holds the final pair now; it is summed this edge
                    if (!w_upstream_busy) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        mac_ena <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture RAM data into MAC operands only for real pairs; bubbles feed zero
    always_ff @(posedge clk) begin
        if (reset || !w_mem_tag.valid) begin
            mac_a0 <= '0;
            mac_b0 <= '0;
            mac_a1 <= '0;
            mac_b1 <= '0;
        end else begin
            mac_a0 <= coef_0;
            mac_b0 <= vec_0;
            mac_a1 <= coef_1;
            mac_b1 <= vec_1;
        end
    end

    // Sum MAC results per row; the closing pair emits the sum and restarts acc
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_sum   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (w_exit_tag.valid) begin
                if (w_exit_tag.last) begin
                    out_sum   <= r_acc + ACC_W'(mac_result);
                    out_row   <= w_exit_tag.row[ROW_W-1:0];
                    out_valid <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc <= r_acc + ACC_W'(mac_result);
                end
            end
        end
    end

endmodule
`default_nettype wire
